// File: rtl/uart_axi_slave_pkg.sv
// Shared constants and state types for the UART AXI4-Lite responder.
package uart_axi_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Register select, taken from address bits [3:2]
  localparam logic [1:0] REG_RX_DATA = 2'd0;
  localparam logic [1:0] REG_TX_DATA = 2'd1;
  localparam logic [1:0] REG_STAT    = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int STAT_RX_NONEMPTY = 0;
  localparam int STAT_RX_FULL     = 1;
  localparam int STAT_TX_EMPTY    = 2;
  localparam int STAT_TX_FULL     = 3;
  localparam int STAT_OVERRUN     = 5;

  typedef enum logic {R_IDLE, R_RESP} rd_state_e;
  typedef enum logic {W_IDLE, W_RESP} wr_state_e;

  function automatic logic [1:0] reg_sel(input logic [31:0] addr);
    return addr[3:2];
  endfunction

endpackage

// File: rtl/uart_axi_slave_fifo.sv
// 8-bit synchronous FIFO with flush; a push into a full FIFO is accepted
// only when a pop frees the slot in the same cycle.
module uart_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [7:0]               din_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [7:0]               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;

  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != FULL_CNT) | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (PW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/uart_axi_slave.sv
// AXI4-Lite responder exposing the UART RX/TX byte FIFOs as four registers:
// RX_DATA (ro), TX_DATA (wo), STAT (ro), CTRL (wo).
module uart_axi_slave
  import uart_axi_slave_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] axi_araddr,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [2:0]  axi_arprot,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  input  logic [31:0] axi_awaddr,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [2:0]  axi_awprot,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rd_state_e   r_state_q;
  logic        arready_q, rvalid_q;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  wr_state_e   w_state_q;
  logic        awready_q, wready_q, bvalid_q;
  logic [1:0]  bresp_q, bresp_d;
  logic        aw_got_q, w_got_q;
  logic [1:0]  awsel_q;
  logic [7:0]  wbyte_q;
  logic        wstrb0_q;

  logic        overrun_q;

  logic        rx_full, rx_empty, tx_full, tx_empty;
  logic [7:0]  rx_head;
  logic [CW-1:0] rx_count, tx_count;

  logic        ar_hs, aw_hs, w_hs, have_aw, have_w, do_write;
  logic [1:0]  rd_sel, wr_sel;
  logic [7:0]  wr_byte;
  logic        wr_strb0;
  logic        rx_pop, rx_push, rx_drop, rx_flush, tx_push, tx_pop, tx_flush, stat_rd;
  logic [31:0] stat_word;

  logic unused_ok;
  assign unused_ok = ^{axi_arprot, axi_awprot, axi_araddr[31:4], axi_araddr[1:0],
                       axi_awaddr[31:4], axi_awaddr[1:0], axi_wdata[31:8],
                       axi_wstrb[3:1], rx_count, tx_count};

  // Read channel
  assign ar_hs   = arready_q & axi_arvalid;
  assign rd_sel  = reg_sel(axi_araddr);
  assign rx_pop  = ar_hs & (rd_sel == REG_RX_DATA) & !rx_empty;
  assign stat_rd = ar_hs & (rd_sel == REG_STAT);

  always_comb begin
    stat_word                   = '0;
    stat_word[STAT_RX_NONEMPTY] = !rx_empty;
    stat_word[STAT_RX_FULL]     = rx_full;
    stat_word[STAT_TX_EMPTY]    = tx_empty;
    stat_word[STAT_TX_FULL]     = tx_full;
    stat_word[STAT_OVERRUN]     = overrun_q;
    rdata_d = '0;
    rresp_d = RESP_OKAY;
    case (rd_sel)
      REG_RX_DATA: rdata_d = rx_empty ? 32'h0 : {24'h0, rx_head};
      REG_STAT:    rdata_d = stat_word;
      default:     rresp_d = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            r_state_q <= R_RESP;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_RESP: begin
          if (axi_rready) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // Write channel: AW and W captured independently, the write fires in the
  // cycle the second of the two arrives.
  assign aw_hs    = awready_q & axi_awvalid;
  assign w_hs     = wready_q & axi_wvalid;
  assign have_aw  = aw_got_q | aw_hs;
  assign have_w   = w_got_q | w_hs;
  assign do_write = (w_state_q == W_IDLE) & have_aw & have_w;
  assign wr_sel   = aw_got_q ? awsel_q : reg_sel(axi_awaddr);
  assign wr_byte  = w_got_q ? wbyte_q : axi_wdata[7:0];
  assign wr_strb0 = w_got_q ? wstrb0_q : axi_wstrb[0];
  assign bresp_d  = (wr_sel == REG_TX_DATA || wr_sel == REG_CTRL) ? RESP_OKAY : RESP_SLVERR;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awsel_q   <= '0;
      wbyte_q   <= '0;
      wstrb0_q  <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (do_write) begin
            w_state_q <= W_RESP;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= bresp_d;
          end else begin
            if (aw_hs) begin
              aw_got_q <= 1'b1;
              awsel_q  <= reg_sel(axi_awaddr);
            end
            if (w_hs) begin
              w_got_q  <= 1'b1;
              wbyte_q  <= axi_wdata[7:0];
              wstrb0_q <= axi_wstrb[0];
            end
            awready_q <= !have_aw;
            wready_q  <= !have_w;
          end
        end
        W_RESP: begin
          if (axi_bready) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  // FIFO control
  assign tx_push  = do_write & (wr_sel == REG_TX_DATA) & wr_strb0;
  assign tx_flush = do_write & (wr_sel == REG_CTRL) & wr_byte[0];
  assign rx_flush = do_write & (wr_sel == REG_CTRL) & wr_byte[1];
  assign tx_pop   = !tx_empty & tx_ready;
  assign rx_push  = rx_valid;
  assign rx_drop  = rx_valid & rx_full & !rx_pop;

  // A new overrun wins over a STAT read clearing it in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           overrun_q <= 1'b0;
    else if (rx_flush) overrun_q <= 1'b0;
    else if (rx_drop)  overrun_q <= 1'b1;
    else if (stat_rd)  overrun_q <= 1'b0;
  end

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push),
    .din_i   (rx_data),
    .pop_i   (rx_pop),
    .flush_i (rx_flush),
    .dout_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .din_i   (wr_byte),
    .pop_i   (tx_pop),
    .flush_i (tx_flush),
    .dout_o  (tx_data),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  assign tx_valid    = !tx_empty;
  assign axi_arready = arready_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;
  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;

endmodule

// File: tb/tb_uart_axi_slave.sv
// Self-checking bench for uart_axi_slave: register-access vector table plus
// hand sequences for FIFO fill/overrun, flush, held responses and mid-transaction reset.
module tb_uart_axi_slave;

  localparam int DEPTH = 16;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk, rst;
  logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic [2:0]  axi_arprot, axi_awprot;
  logic [1:0]  axi_rresp, axi_bresp;
  logic [3:0]  axi_wstrb;
  logic [7:0]  rx_data, tx_data;
  logic        rx_valid, tx_valid, tx_ready;

  uart_axi_slave #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_arprot(axi_arprot), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_awprot(axi_awprot), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [33:0] rd_exp_q[$];
  logic [1:0]  wr_exp_q[$];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int hold);
    int n;
    logic [33:0] e;
    rd_exp_q.push_back({exp_resp, exp_data});
    @(negedge clk);
    axi_araddr  = addr;
    axi_arvalid = 1'b1;
    n = 0;
    while (!axi_arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("arready_wait", axi_arready, 1);
    @(negedge clk);
    axi_arvalid = 1'b0;
    chk("rvalid_latency", axi_rvalid, 1);
    chk("arready_busy", axi_arready, 0);
    e = rd_exp_q.pop_front();
    chk("rdata", axi_rdata, e[31:0]);
    chk("rresp", axi_rresp, e[33:32]);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk("rvalid_hold", axi_rvalid, 1);
      chk("rdata_hold", axi_rdata, e[31:0]);
      chk("rresp_hold", axi_rresp, e[33:32]);
    end
    axi_rready = 1'b1;
    @(negedge clk);
    axi_rready = 1'b0;
    chk("rvalid_clear", axi_rvalid, 0);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input logic [1:0] exp_resp,
                           input int hold, output int lat, output logic txv_at_b);
    int c;
    bit aw_done, w_done, aw_hit, w_hit;
    logic [1:0] e;
    wr_exp_q.push_back(exp_resp);
    aw_done = 0;
    w_done  = 0;
    c = 0;
    @(negedge clk);
    axi_awaddr = addr;
    axi_wdata  = data;
    axi_wstrb  = strb;
    while (!(aw_done && w_done) && c < 40) begin
      axi_awvalid = !aw_done && (c >= aw_dly);
      axi_wvalid  = !w_done && (c >= w_dly);
      aw_hit = axi_awvalid && axi_awready;
      w_hit  = axi_wvalid && axi_wready;
      @(negedge clk);
      aw_done = aw_done | aw_hit;
      w_done  = w_done | w_hit;
      c++;
    end
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    lat = c;
    txv_at_b = tx_valid;
    chk("bvalid", axi_bvalid, 1);
    e = wr_exp_q.pop_front();
    chk("bresp", axi_bresp, e);
    chk("awready_busy", {axi_awready, axi_wready}, 2'b00);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk("bvalid_hold", axi_bvalid, 1);
      chk("bresp_hold", axi_bresp, e);
    end
    axi_bready = 1'b1;
    @(negedge clk);
    axi_bready = 1'b0;
    chk("bvalid_clear", axi_bvalid, 0);
  endtask

  task automatic rx_send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    int   lat;
    logic txv;

    rst = 1'b1;
    axi_araddr = '0; axi_arvalid = 0; axi_arprot = '0; axi_rready = 0;
    axi_awaddr = '0; axi_awvalid = 0; axi_awprot = '0;
    axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 0; axi_bready = 0;
    rx_data = '0; rx_valid = 0; tx_ready = 0;

    tbl[0]  = '{1'b0, 32'h7F00_0008, 32'h0,         4'h0, 32'h04, OKAY};
    tbl[1]  = '{1'b0, 32'h7F00_0000, 32'h0,         4'h0, 32'h00, OKAY};
    tbl[2]  = '{1'b0, 32'h7F00_0004, 32'h0,         4'h0, 32'h00, SLVERR};
    tbl[3]  = '{1'b0, 32'h7F00_000C, 32'h0,         4'h0, 32'h00, SLVERR};
    tbl[4]  = '{1'b1, 32'h7F00_0000, 32'h11,        4'h1, 32'h00, SLVERR};
    tbl[5]  = '{1'b1, 32'h7F00_0008, 32'h22,        4'h1, 32'h00, SLVERR};
    tbl[6]  = '{1'b1, 32'h7F00_0004, 32'hA5,        4'h0, 32'h00, OKAY};
    tbl[7]  = '{1'b0, 32'h7F00_0008, 32'h0,         4'h0, 32'h04, OKAY};
    tbl[8]  = '{1'b1, 32'h7F00_0004, 32'h1234_56A5, 4'h1, 32'h00, OKAY};
    tbl[9]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'h00, OKAY};
    tbl[10] = '{1'b1, 32'h7F00_000C, 32'h1,         4'hF, 32'h00, OKAY};
    tbl[11] = '{1'b0, 32'hFFFF_FFF8, 32'h0,         4'h0, 32'h04, OKAY};
    tbl[12] = '{1'b1, 32'h7F00_000C, 32'h2,         4'hF, 32'h00, OKAY};

    // Reset values, then readies one cycle after release
    repeat (3) @(negedge clk);
    chk("rst_readies", {axi_arready, axi_awready, axi_wready}, 3'b000);
    chk("rst_valids", {axi_rvalid, axi_bvalid, tx_valid}, 3'b000);
    chk("rst_rdata", axi_rdata, 0);
    chk("rst_resps", {axi_rresp, axi_bresp}, 4'b0000);
    rst = 1'b0;
    @(negedge clk);
    chk("readies_after_rst", {axi_arready, axi_awready, axi_wready}, 3'b111);

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].wr)
        axi_write(tbl[i].addr, tbl[i].wdata, tbl[i].strb, 0, 0, tbl[i].exp_resp, 0, lat, txv);
      else
        axi_read(tbl[i].addr, tbl[i].exp_data, tbl[i].exp_resp, 0);
    end

    // RX bytes come back in order, then empty reads as 0
    rx_send(8'h41); rx_send(8'h42); rx_send(8'h43);
    axi_read(32'h7F00_0000, 32'h41, OKAY, 0);
    axi_read(32'h7F00_0000, 32'h42, OKAY, 0);
    axi_read(32'h7F00_0000, 32'h43, OKAY, 0);
    axi_read(32'h7F00_0000, 32'h00, OKAY, 0);

    // AW now, W three cycles later
    axi_write(32'h7F00_0004, 32'h55, 4'b0001, 0, 3, OKAY, 0, lat, txv);
    chk("bvalid_cycle", lat, 4);
    chk("tx_valid_after_push", tx_valid, 1);
    chk("tx_data_head", tx_data, 32'h55);
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk("tx_drained", tx_valid, 0);

    // W before AW
    axi_write(32'h7F00_0004, 32'h3C, 4'b0001, 2, 0, OKAY, 0, lat, txv);
    chk("w_first_lat", lat, 3);
    chk("w_first_data", tx_data, 32'h3C);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;

    // Overfill RX: overrun set, cleared by the first STAT read
    for (int i = 0; i <= DEPTH; i++) rx_send(8'h10 + 8'(i));
    axi_read(32'h7F00_0008, 32'h27, OKAY, 0);
    axi_read(32'h7F00_0008, 32'h07, OKAY, 0);
    axi_read(32'h7F00_0000, 32'h10, OKAY, 0);
    axi_read(32'h7F00_0000, 32'h11, OKAY, 0);

    // Flush both FIFOs
    axi_write(32'h7F00_0004, 32'h66, 4'b0001, 0, 0, OKAY, 0, lat, txv);
    chk("tx_nonempty_before_flush", tx_valid, 1);
    axi_write(32'h7F00_000C, 32'h3, 4'hF, 0, 0, OKAY, 0, lat, txv);
    chk("tx_valid_after_flush", txv, 0);
    axi_read(32'h7F00_0008, 32'h04, OKAY, 0);

    // Error responses held while the master stalls
    axi_read(32'h7F00_0004, 32'h0, SLVERR, 5);
    axi_write(32'h7F00_0008, 32'hFF, 4'hF, 0, 0, SLVERR, 5, lat, txv);

    // Reset mid-read and with a half-captured write
    rx_send(8'h77);
    axi_write(32'h7F00_0004, 32'h88, 4'b0001, 0, 0, OKAY, 0, lat, txv);
    @(negedge clk);
    axi_araddr  = 32'h7F00_0008;
    axi_arvalid = 1'b1;
    @(negedge clk);
    axi_arvalid = 1'b0;
    chk("pre_rst_rvalid", axi_rvalid, 1);
    axi_awaddr  = 32'h7F00_000C;
    axi_awvalid = 1'b1;
    @(negedge clk);
    axi_awvalid = 1'b0;
    chk("pre_rst_half_write", {axi_awready, axi_wready}, 2'b01);
    rst = 1'b1;
    #1;
    chk("mid_rst_valids", {axi_rvalid, axi_bvalid, tx_valid}, 3'b000);
    chk("mid_rst_readies", {axi_arready, axi_awready, axi_wready}, 3'b000);
    chk("mid_rst_rdata", axi_rdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_resp_after_rst", {axi_rvalid, axi_bvalid}, 2'b00);
    end
    axi_read(32'h7F00_0008, 32'h04, OKAY, 0);
    axi_read(32'h7F00_0000, 32'h00, OKAY, 0);
    axi_write(32'h7F00_0004, 32'h99, 4'b0001, 0, 0, OKAY, 0, lat, txv);
    chk("post_rst_tx_data", tx_data, 32'h99);
    chk("post_rst_tx_valid", tx_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
